// File: rtl/mvu_pkg.sv
// Shared widths, response tag and reader state encoding for the MVU read channel.
package mvu_pkg;

    localparam int BDBANKA  = 15;
    localparam int BDBANKW  = 64;
    localparam int BLEN     = 15;
    localparam int TAG_SELW = 8;

    typedef struct packed {
        logic [TAG_SELW-1:0] sel;
        logic                last;
    } rdc_tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rdc_rd_state_e;

endpackage

// File: rtl/mvu_rdc_fifo.sv
// Synchronous FIFO with occupancy count; head entry is read straight from storage.
module mvu_rdc_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [W-1:0]    din,
    input  logic            pop,
    output logic [W-1:0]    dout,
    output logic            empty,
    output logic [CNTW-1:0] count
);
    import mvu_pkg::*;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mvu_rdc_reader.sv
// Host-side read initiator: issues strided, credit-limited reads to one MVU and
// streams the returned words out in request order with a last marker.
module mvu_rdc_reader #(
    parameter int NMVU      = 1,
    parameter int N         = mvu_pkg::BDBANKW,
    parameter int BDBANKA   = mvu_pkg::BDBANKA,
    parameter int RDLAT     = 2,
    parameter int FIFODEPTH = 4,
    parameter int BMVUSEL   = (NMVU > 1) ? $clog2(NMVU) : 1,
    parameter int BLEN      = mvu_pkg::BLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BMVUSEL-1:0]      mvu_sel,
    input  logic [BDBANKA-1:0]      base_addr,
    input  logic [BDBANKA-1:0]      stride,
    input  logic [BLEN-1:0]         length,
    output logic                    busy,
    output logic                    done,
    output logic [NMVU-1:0]         rdc_en,
    input  logic [NMVU-1:0]         rdc_grnt,
    output logic [NMVU*BDBANKA-1:0] rdc_addr,
    input  logic [NMVU*N-1:0]       rdc_word,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N-1:0]            out_word,
    output logic                    out_last
);
    import mvu_pkg::*;

    localparam int CW = $clog2(FIFODEPTH + 1) + 1;

    rdc_rd_state_e       state;
    rdc_rd_state_e       state_nxt;
    logic                done_r;
    logic [BMVUSEL-1:0]  sel_r;
    logic [BDBANKA-1:0]  addr_r;
    logic [BDBANKA-1:0]  stride_r;
    logic [BLEN-1:0]     remaining;

    logic                issue_en;
    logic                granted;
    logic                credit_ok;
    logic                last_hs;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       fifo_count;

    logic [RDLAT-1:0]    vld_p;
    rdc_tag_t            tag_p [RDLAT];
    logic [N-1:0]        cap_word;
    logic [N:0]          head;
    logic                fifo_empty;

    a_depth: assert property (@(posedge clk) FIFODEPTH >= RDLAT + 1);

    // Requests still in the return pipe count against FIFO space, so a word
    // arriving from the channel always has a slot waiting for it.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RDLAT; i++) inflight = inflight + CW'(vld_p[i]);
    end

    assign credit_ok = (inflight + fifo_count) < CW'(FIFODEPTH);
    assign busy      = (state != IDLE);
    assign done      = done_r;
    assign out_valid = !fifo_empty;
    assign out_word  = head[N-1:0];
    assign out_last  = !fifo_empty && head[N];
    assign last_hs   = out_valid && out_ready && out_last;

    // Next-state logic and channel request outputs.
    always_comb begin
        state_nxt = state;
        issue_en  = (state == ISSUE) && credit_ok;
        rdc_en    = '0;
        rdc_addr  = '0;
        if (issue_en) rdc_en[sel_r] = 1'b1;
        for (int m = 0; m < NMVU; m++) begin
            if (state == ISSUE && sel_r == BMVUSEL'(m))
                rdc_addr[m*BDBANKA +: BDBANKA] = addr_r;
        end
        granted = |(rdc_en & rdc_grnt);
        case (state)
            IDLE:    if (start && length != '0) state_nxt = ISSUE;
            ISSUE:   if (granted && remaining == BLEN'(1)) state_nxt = DRAIN;
            DRAIN:   if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= (state == IDLE && start && length == '0) ||
                      (state == DRAIN && last_hs);
        end
    end

    // Job registers: latched on an idle start, advanced on each granted request.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            sel_r     <= mvu_sel;
            addr_r    <= base_addr;
            stride_r  <= stride;
            remaining <= length;
        end else if (granted) begin
            addr_r    <= addr_r + stride_r;
            remaining <= remaining - BLEN'(1);
        end
    end

    // Return pipe valids: cleared on reset so late words from an aborted job drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= granted;
            for (int i = 1; i < RDLAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Return pipe tags travelling alongside the valids.
    always_ff @(posedge clk) begin
        tag_p[0].sel  <= TAG_SELW'(sel_r);
        tag_p[0].last <= (remaining == BLEN'(1));
        for (int i = 1; i < RDLAT; i++) tag_p[i] <= tag_p[i-1];
    end

    // Select the returning MVU's word slice named by the exiting tag.
    always_comb begin
        cap_word = '0;
        for (int m = 0; m < NMVU; m++) begin
            if (tag_p[RDLAT-1].sel == TAG_SELW'(m)) cap_word = rdc_word[m*N +: N];
        end
    end

    mvu_rdc_fifo #(
        .W     (N + 1),
        .DEPTH (FIFODEPTH),
        .CNTW  (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_p[RDLAT-1]),
        .din   ({tag_p[RDLAT-1].last, cap_word}),
        .pop   (out_ready),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_mvu_rdc_reader.sv
// Directed bench for mvu_rdc_reader with a two-MVU responder model and
// address/word scoreboards filled when each job is launched.
module tb_mvu_rdc_reader;

    localparam int NMVU = 2;
    localparam int N    = 64;
    localparam int AW   = 15;
    localparam int LW   = 15;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [0:0]           mvu_sel;
    logic [AW-1:0]        base_addr;
    logic [AW-1:0]        stride;
    logic [LW-1:0]        length;
    logic                 busy;
    logic                 done;
    logic [NMVU-1:0]      rdc_en;
    logic [NMVU-1:0]      rdc_grnt;
    logic [NMVU*AW-1:0]   rdc_addr;
    logic [NMVU*N-1:0]    rdc_word;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out_word;
    logic                 out_last;

    int total = 0;
    int bad   = 0;

    logic [15:0] addr_q [$];
    logic [64:0] word_q [$];

    logic mon_on   = 1'b0;
    logic zstart   = 1'b0;
    logic done_due = 1'b0;
    int   cyc      = 0;
    int   grants   = 0;
    int   en_seen  = 0;
    int   g_first  = -1;
    int   g_last   = -1;
    int   v_first  = -1;

    logic [NMVU-1:0][N-1:0] rsp_p0;
    logic [NMVU-1:0][N-1:0] rsp_p1;

    mvu_rdc_reader #(
        .NMVU      (NMVU),
        .N         (N),
        .BDBANKA   (AW),
        .RDLAT     (2),
        .FIFODEPTH (4),
        .BMVUSEL   (1),
        .BLEN      (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mvu_sel   (mvu_sel),
        .base_addr (base_addr),
        .stride    (stride),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rdc_en    (rdc_en),
        .rdc_grnt  (rdc_grnt),
        .rdc_addr  (rdc_addr),
        .rdc_word  (rdc_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] mem_word(input int m, input logic [AW-1:0] a);
        logic [3:0] mt;
        mt = 4'(m);
        return {mt, 45'h0, a} ^ 64'h0123_4567_89AB_0000;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Responder: a granted request returns its word two cycles later.
    always @(posedge clk) begin
        for (int m = 0; m < NMVU; m++) begin
            if (rdc_en[m] && rdc_grnt[m])
                rsp_p0[m] <= mem_word(m, rdc_addr[m*AW +: AW]);
            else
                rsp_p0[m] <= 64'hBAD0_0000_0000_0000 | 64'(m);
            rsp_p1[m] <= rsp_p0[m];
        end
    end
    assign rdc_word = rsp_p1;

    // Monitor: sample mid-cycle, before the edge that performs the transfer.
    always @(negedge clk) begin
        if (mon_on) begin
            check("done", {127'd0, done}, {127'd0, done_due});
            done_due = rst_n && ((out_valid && out_ready && out_last) || zstart);
            if (rst_n) begin
                if (|rdc_en) en_seen++;
                for (int m = 0; m < NMVU; m++) begin
                    if (rdc_en[m] && rdc_grnt[m]) begin
                        if (g_first < 0) g_first = cyc;
                        g_last = cyc;
                        grants++;
                        if (addr_q.size() > 0)
                            check("addr", {112'd0, 1'(m), rdc_addr[m*AW +: AW]}, {112'd0, addr_q.pop_front()});
                        else
                            check("addr_unexpected", 128'(addr_q.size()), 128'd1);
                    end
                end
                if (out_valid && v_first < 0) v_first = cyc;
                if (out_valid && out_ready) begin
                    if (word_q.size() > 0)
                        check("word", {63'd0, out_last, out_word}, {63'd0, word_q.pop_front()});
                    else
                        check("word_unexpected", 128'(word_q.size()), 128'd1);
                end
            end
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic sel, input logic [AW-1:0] base, input logic [AW-1:0] strd,
                            input logic [LW-1:0] len, input bit accept);
        logic [AW-1:0] a;
        mvu_sel   = sel;
        base_addr = base;
        stride    = strd;
        length    = len;
        start     = 1'b1;
        if (accept) begin
            a = base;
            for (int i = 0; i < int'(len); i++) begin
                addr_q.push_back({sel, a});
                word_q.push_back({(i == int'(len) - 1), mem_word(int'(sel), a)});
                a = a + strd;
            end
            if (len == '0) zstart = 1'b1;
        end
        tick(1);
        start  = 1'b0;
        zstart = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check("idle_timeout", {127'd0, busy}, 128'd0);
        tick(1);
        check("addr_q_empty", 128'(addr_q.size()), 128'd0);
        check("word_q_empty", 128'(word_q.size()), 128'd0);
    endtask

    task automatic new_job_stats();
        grants  = 0;
        en_seen = 0;
        g_first = -1;
        g_last  = -1;
        v_first = -1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        mvu_sel   = 1'b0;
        base_addr = '0;
        stride    = '0;
        length    = '0;
        rdc_grnt  = 2'b11;
        out_ready = 1'b1;
        tick(2);
        check("rst_busy",      {127'd0, busy},      128'd0);
        check("rst_done",      {127'd0, done},      128'd0);
        check("rst_rdc_en",    128'(rdc_en),        128'd0);
        check("rst_rdc_addr",  128'(rdc_addr),      128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_last",  {127'd0, out_last},  128'd0);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        tick(1);

        // Streaming job at full rate.
        new_job_stats();
        do_start(1'b0, 15'h010, 15'd1, 15'd4, 1'b1);
        check("busy_after_start", {127'd0, busy}, 128'd1);
        wait_idle(40);
        check("grants_4", 128'(grants), 128'd4);
        check("grant_consecutive", 128'(g_last - g_first), 128'd3);
        check("first_valid_latency", 128'(v_first - g_first), 128'd3);

        // Grant withheld (with a stray grant on the other MVU), then released.
        new_job_stats();
        rdc_grnt = 2'b10;
        do_start(1'b0, 15'h000, 15'd2, 15'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("hold_en",   128'(rdc_en),   128'd1);
            check("hold_addr", 128'(rdc_addr), 128'd0);
            tick(1);
        end
        check("hold_no_grant", 128'(grants), 128'd0);
        rdc_grnt = 2'b11;
        wait_idle(40);
        check("grants_3", 128'(grants), 128'd3);

        // Back-pressure: credits stop issue at four outstanding words.
        new_job_stats();
        out_ready = 1'b0;
        do_start(1'b0, 15'h100, 15'd3, 15'd8, 1'b1);
        tick(5);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {127'd0, out_valid}, 128'd1);
            check("bp_word_stable", {64'd0, out_word}, {64'd0, word_q[0][63:0]});
            tick(1);
        end
        check("bp_en_off", 128'(rdc_en), 128'd0);
        check("bp_grants", 128'(grants), 128'd4);
        out_ready = 1'b1;
        wait_idle(60);
        check("grants_8", 128'(grants), 128'd8);

        // Address wrap at the top of the bank.
        new_job_stats();
        do_start(1'b0, 15'h7FFE, 15'd1, 15'd4, 1'b1);
        wait_idle(40);

        // Zero-length job.
        new_job_stats();
        do_start(1'b0, 15'h055, 15'd1, 15'd0, 1'b1);
        check("zlen_done", {127'd0, done}, 128'd1);
        check("zlen_busy", {127'd0, busy}, 128'd0);
        tick(3);
        check("zlen_no_en", 128'(en_seen), 128'd0);

        // Starts while busy are ignored.
        new_job_stats();
        do_start(1'b0, 15'h300, 15'd1, 15'd4, 1'b1);
        do_start(1'b1, 15'h200, 15'd1, 15'd5, 1'b0);
        do_start(1'b0, 15'h111, 15'd1, 15'd0, 1'b0);
        wait_idle(40);
        check("busy_start_grants", 128'(grants), 128'd4);

        // Abort a job on MVU 1 with reset, then read from MVU 0.
        new_job_stats();
        do_start(1'b1, 15'h050, 15'd1, 15'd6, 1'b1);
        begin
            int n = 0;
            while (grants < 2 && n < 20) begin
                tick(1);
                n++;
            end
        end
        check("abort_two_grants", 128'(grants), 128'd2);
        rst_n = 1'b0;
        addr_q.delete();
        word_q.delete();
        tick(1);
        check("abort_en",    128'(rdc_en),        128'd0);
        check("abort_valid", {127'd0, out_valid}, 128'd0);
        check("abort_busy",  {127'd0, busy},      128'd0);
        rst_n = 1'b1;
        tick(4);
        check("abort_no_stale", {127'd0, out_valid}, 128'd0);
        new_job_stats();
        do_start(1'b0, 15'h020, 15'd1, 15'd3, 1'b1);
        wait_idle(40);
        check("post_abort_grants", 128'(grants), 128'd3);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mvu_rdc_reader.md
Name: mvu_rdc_reader

Overview:
Host-side initiator for the MVU data-memory read channel (rdc_en / rdc_grnt / rdc_addr / rdc_word). It takes a read job (MVU select, base address, stride, length) and issues granted read requests to the selected MVU. Returned data words go out as a valid/ready stream. It pairs with mvutop, which is the responder on this channel, and is used for result readback after quantization and for the integration bench.

Parameters:
NMVU, 1, number of MVUs on the channel.
N, 64, data word width (= BDBANKW).
BDBANKA, 15, data bank address width.
RDLAT, 2, cycles from granted request to rdc_word valid.
FIFODEPTH, 4, output buffer depth in words; must be >= RDLAT+1 (SVA check).
BMVUSEL, (NMVU>1 ? $clog2(NMVU) : 1), MVU select width.
BLEN, 15, job length width.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle job launch; accepted only when busy=0
mvu_sel  input  BMVUSEL  target MVU, sampled on start
base_addr  input  BDBANKA  first read address, sampled on start
stride  input  BDBANKA  address increment (unsigned), sampled on start
length  input  BLEN  number of words to read, sampled on start
busy  output  1  job in progress
done  output  1  one-cycle pulse when the job completes
rdc_en  output  NMVU  read request, one-hot on mvu_sel
rdc_grnt  input  NMVU  per-MVU grant; request accepted when en&grnt
rdc_addr  output  NMVU*BDBANKA  read address, replicated on the selected slice and zero on the others
rdc_word  input  NMVU*N  returned data, per-MVU slice
out_valid  output  1  out_word valid
out_ready  input  1  downstream ready
out_word  output  N  read data, in request order
out_last  output  1  marks the final word of the job

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, busy=0, done=0, rdc_en=0, rdc_addr=0, out_valid=0, out_last=0. FIFO and in-flight pipeline are flushed. Reset mid-job aborts the job with no done pulse. Words returning after reset are discarded.
- FSM states:
  - IDLE: on start with length!=0, latch the job and go to ISSUE, busy=1. On start with length==0, pulse done next cycle and stay IDLE; no rdc_en is ever asserted.
  - ISSUE: assert rdc_en[sel] when credits allow. Credits allow when in-flight count + FIFO occupancy < FIFODEPTH.
    - On en&grnt: addr += stride modulo 2^BDBANKA (wraps silently), remaining -= 1.
    - Without grant: rdc_en and rdc_addr hold stable; no address advance.
    - When a granted request takes remaining to 0, go to DRAIN.
  - DRAIN: wait until all words are returned and the last word is handshaken (out_valid&out_ready with out_last). Then go to IDLE with busy=0 and done=1 for exactly one cycle, on the cycle after that handshake.
- Response path: a RDLAT-deep valid/tag shift register records each granted request. The tag carries sel and a last flag. When an entry exits, rdc_word[sel] is captured into the FIFO, with no stall allowed. The credit rule guarantees the FIFO never overflows.
- Output: out_word/out_last come from the FIFO head, registered. out_valid=1 when the FIFO is not empty. Data and last stay stable while out_valid=1 and out_ready=0.
- Throughput: with grant and ready held high, one request per cycle sustained. First out_valid appears RDLAT+1 cycles after the first granted request.
- start while busy=1 is ignored.
- A grant on a non-selected MVU is ignored.
- Simultaneous FIFO push and pop is allowed at full occupancy.

Decomposition:
- Shared package mvu_pkg:
  - widths BDBANKA, BDBANKW, BLEN.
  - rdc_tag_t struct {sel, last}.
  - state enum rdc_rd_state_e {IDLE, ISSUE, DRAIN}.
- Sub-module mvu_rdc_fifo: synchronous FIFO with count output, parameterised on width and depth, sync active-low reset. Instantiated once for {last, word}.

Test Plan:
- base=0x010, stride=1, length=4, grant and ready always high → rdc_addr 0x010..0x013 on 4 consecutive cycles; words out in order; out_last on the 4th word only; done one cycle after the last handshake.
- rdc_grnt low for 3 cycles during ISSUE (length=3, stride=2, base=0) → rdc_en and rdc_addr=0 held stable for 3 cycles, then addresses 0, 2, 4; no duplicate or skipped words.
- out_ready low for 10 cycles (length=8) → rdc_en deasserts once credits reach FIFODEPTH=4; no word lost or reordered; all 8 words delivered after ready returns.
- base=0x7FFE, stride=1, length=4 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- length=0 start → done pulses next cycle, busy stays 0, rdc_en never asserted. Also: start while busy has no effect.
- NMVU=2, mvu_sel=1, reset asserted after 2 grants → rdc_en goes to 0, out_valid goes to 0, no done pulse; a following job (sel=0) reads correctly, with no stale words from the aborted job.
